// File: rtl/mux8_sched_pkg.sv
// mux8_sched_pkg: shared definitions for the 8-requester round-robin mux scheduler.
//   sched_state_t : FSM state encoding (IDLE / XFER)
//   NUM_REQ, SEL_W: requester count and select width
//   rr_pick()     : round-robin search helper
package mux8_sched_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } sched_state_t;

  // Returns the first set bit of req searching upward from last+1, wrapping
  // modulo NUM_REQ. The 3-bit addition wraps on its own. Callers only use
  // the result when req is non-zero; with req == 0 it returns last.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [SEL_W-1:0]   last);
    logic [SEL_W-1:0] idx;
    logic             found;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = last + SEL_W'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/mux8_sel_dp.sv
// mux8_sel_dp: combinational 8:1 single-bit data selector.
//   din  [7:0] : data inputs I0..I7
//   sel  [2:0] : select {S2,S1,S0}
//   dout       : din[sel]
module mux8_sel_dp
  import mux8_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] din,
  input  logic [SEL_W-1:0]   sel,
  output logic               dout
);

  assign dout = din[sel];

endmodule

// File: rtl/mux8_rr_scheduler.sv
// mux8_rr_scheduler: round-robin scheduler sharing one 8:1 mux between eight
// requesters, delivering the registered mux sample over valid/ready with
// bounded bursts per grant.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   req[7:0], din[7:0]  : request lines and data inputs
//   out_ready           : downstream accept
//   out_valid, out_data : registered beat
//   sel[2:0], gnt[7:0]  : current select and one-hot grant
//   ack[7:0]            : pulses on the granted bit when a beat is accepted
//   busy                : FSM not in IDLE
// Optional build macro: MUX8_SCHED_PRIO0_EN (requester 0 wins every
// arbitration and pre-empts bursts at the next accept).
//
// state | meaning
// IDLE  | no beat held; waiting for any req
// XFER  | out_valid high, beat from gnt held until accepted
module mux8_rr_scheduler
  import mux8_sched_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] din,
  input  logic               out_ready,
  output logic               out_valid,
  output logic               out_data,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] ack,
  output logic               busy
);

  localparam logic [CNT_W:0] LP_MAX_BURST = (CNT_W+1)'(MAX_BURST);

  sched_state_t       r_state;
  logic               r_out_valid;
  logic               r_out_data;
  logic [SEL_W-1:0]   r_sel;
  logic [NUM_REQ-1:0] r_gnt;
  logic [CNT_W-1:0]   r_burst_cnt;
  logic [SEL_W-1:0]   r_last_grant;

  logic               w_accept;
  logic               w_prio;
  logic               w_cont;
  logic               w_upd_last;
  logic [SEL_W-1:0]   w_rr;
  logic [SEL_W-1:0]   w_pick;
  logic [NUM_REQ-1:0] w_pick_onehot;
  logic [SEL_W-1:0]   w_mux_sel;
  logic               w_mux_out;
  logic [CNT_W:0]     w_cnt_inc;

`ifdef MUX8_SCHED_PRIO0_EN
  assign w_prio = req[0];
`else
  assign w_prio = 1'b0;
`endif

  assign w_accept      = r_out_valid & out_ready;
  assign w_cnt_inc     = {1'b0, r_burst_cnt} + 1'b1;
  assign w_rr          = rr_pick(req, r_last_grant);
  assign w_pick        = w_prio ? '0 : w_rr;
  // Priority grants leave last_grant alone so the 1..7 rotation survives them.
  assign w_upd_last    = ~w_prio;
  assign w_pick_onehot = NUM_REQ'(1) << w_pick;
  // Stay on the current owner only while it still requests, the burst has
  // room, and (with priority) requester 0 is not waiting to pre-empt.
  assign w_cont        = req[r_sel] && (w_cnt_inc < LP_MAX_BURST) &&
                         !(w_prio && (r_sel != '0));
  // The mux is steered by the next owner so out_data captures the right input
  // in the same edge that loads the new grant.
  assign w_mux_sel     = ((r_state == XFER) && w_cont) ? r_sel : w_pick;

  mux8_sel_dp u_sel_dp (
    .din  (din),
    .sel  (w_mux_sel),
    .dout (w_mux_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_out_valid  <= 1'b0;
      r_out_data   <= 1'b0;
      r_sel        <= '0;
      r_gnt        <= '0;
      r_burst_cnt  <= '0;
      r_last_grant <= SEL_W'(NUM_REQ-1);
    end else begin
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_state     <= XFER;
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux_out;
            r_sel       <= w_pick;
            r_gnt       <= w_pick_onehot;
            r_burst_cnt <= '0;
            if (w_upd_last) r_last_grant <= w_pick;
          end
        end
        XFER: begin
          if (w_accept) begin
            if (w_cont) begin
              r_out_data  <= w_mux_out;
              r_burst_cnt <= w_cnt_inc[CNT_W-1:0];
            end else if (|req) begin
              r_out_data  <= w_mux_out;
              r_sel       <= w_pick;
              r_gnt       <= w_pick_onehot;
              r_burst_cnt <= '0;
              if (w_upd_last) r_last_grant <= w_pick;
            end else begin
              r_state     <= IDLE;
              r_out_valid <= 1'b0;
              r_gnt       <= '0;
              r_burst_cnt <= '0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign sel       = r_sel;
  assign gnt       = r_gnt;
  // Combinational so it marks exactly the accepting edge and is always a
  // subset of the grant that owns the beat.
  assign ack       = w_accept ? r_gnt : '0;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
module tb_mux8_rr_scheduler;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] din;
  logic       out_ready;
  logic       out_valid;
  logic       out_data;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic [7:0] ack;
  logic       busy;

  int checks = 0;
  int errors = 0;

  mux8_rr_scheduler #(.MAX_BURST(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .din       (din),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .sel       (sel),
    .gnt       (gnt),
    .ack       (ack),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_n = 1'b0; req = '0; din = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; din = '0; out_ready = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, sel, gnt, ack, busy} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%b sel=%0d gnt=%h ack=%h busy=%b, expected all zero",
               out_valid, out_data, sel, gnt, ack, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, gnt, busy} !== 10'd0) begin
      errors++;
      $display("FAIL reset_idle: got v=%b gnt=%h busy=%b, expected 0/00/0", out_valid, gnt, busy);
    end
  endtask

  // Requester 0 alone: 1-cycle latency, then continuous beats across the
  // 4-beat burst boundary with data resampled each beat.
  task automatic test_single_burst();
    logic d_cur;
    apply_reset();
    req = 8'h01; din = 8'h01; out_ready = 1'b1;
    d_cur = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_data, sel, gnt, ack, busy} !== {1'b1, d_cur, 3'd0, 8'h01, 8'h01, 1'b1}) begin
        errors++;
        $display("FAIL single_beat%0d: got v=%b d=%b sel=%0d gnt=%h ack=%h busy=%b, expected v=1 d=%b sel=0 gnt=01 ack=01 busy=1",
                 n, out_valid, out_data, sel, gnt, ack, busy, d_cur);
      end
      d_cur  = ~d_cur;
      din[0] = d_cur;
    end
    req = '0;
    @(negedge clk);
    checks++;
    if ({out_valid, gnt, busy} !== 10'd0) begin
      errors++;
      $display("FAIL single_idle: got v=%b gnt=%h busy=%b, expected 0/00/0", out_valid, gnt, busy);
    end
  endtask

  // All requesting: 4 beats each, order 0..7 then wrap to 0, no gaps.
  task automatic test_round_robin();
    logic [7:0] pat;
    int         idx;
    logic [7:0] g;
    apply_reset();
    pat = 8'b1010_0110;
    req = 8'hFF; din = pat; out_ready = 1'b1;
    for (int n = 0; n < 36; n++) begin
      @(negedge clk);
      idx = (n / 4) % 8;
      g   = 8'h01 << idx;
      checks++;
      if ({out_valid, out_data, sel, gnt, ack} !== {1'b1, pat[idx], 3'(idx), g, g}) begin
        errors++;
        $display("FAIL rr_beat%0d: got v=%b d=%b sel=%0d gnt=%h ack=%h, expected v=1 d=%b sel=%0d gnt=%h ack=%h",
                 n, out_valid, out_data, sel, gnt, ack, pat[idx], idx, g, g);
      end
    end
    req = '0;
    @(negedge clk);
  endtask

  // Stalled beat: everything frozen despite din toggles and req drop; one ack.
  task automatic test_stall();
    apply_reset();
    req = 8'h08; din = 8'h08; out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, sel, gnt, ack} !== {1'b1, 1'b1, 3'd3, 8'h08, 8'h00}) begin
      errors++;
      $display("FAIL stall_grant: got v=%b d=%b sel=%0d gnt=%h ack=%h, expected v=1 d=1 sel=3 gnt=08 ack=00",
               out_valid, out_data, sel, gnt, ack);
    end
    for (int c = 0; c < 5; c++) begin
      din = din ^ 8'h08;
      if (c == 1) req = '0;
      @(negedge clk);
      checks++;
      if ({out_valid, out_data, sel, gnt, ack, busy} !== {1'b1, 1'b1, 3'd3, 8'h08, 8'h00, 1'b1}) begin
        errors++;
        $display("FAIL stall_hold%0d: got v=%b d=%b sel=%0d gnt=%h ack=%h busy=%b, expected v=1 d=1 sel=3 gnt=08 ack=00 busy=1",
                 c, out_valid, out_data, sel, gnt, ack, busy);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (ack !== 8'h08) begin
      errors++;
      $display("FAIL stall_ack: got ack=%h, expected 08", ack);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, sel, gnt, ack, busy} !== {1'b0, 3'd3, 8'h00, 8'h00, 1'b0}) begin
        errors++;
        $display("FAIL stall_idle%0d: got v=%b sel=%0d gnt=%h ack=%h busy=%b, expected v=0 sel=3 gnt=00 ack=00 busy=0",
                 c, out_valid, sel, gnt, ack, busy);
      end
    end
  endtask

  // last_grant=6, then req 0 and 1: wrap to 0, then 1.
  task automatic test_wrap();
    apply_reset();
    req = 8'h40; din = 8'h00; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({sel, gnt, ack} !== {3'd6, 8'h40, 8'h40}) begin
      errors++;
      $display("FAIL wrap_g6: got sel=%0d gnt=%h ack=%h, expected sel=6 gnt=40 ack=40", sel, gnt, ack);
    end
    req = '0;
    @(negedge clk);
    req = 8'h03; din = 8'h01;
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, sel, gnt, ack} !== {1'b1, 1'b1, 3'd0, 8'h01, 8'h01}) begin
      errors++;
      $display("FAIL wrap_g0: got v=%b d=%b sel=%0d gnt=%h ack=%h, expected v=1 d=1 sel=0 gnt=01 ack=01",
               out_valid, out_data, sel, gnt, ack);
    end
    req = 8'h02; din = 8'h02;
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, sel, gnt, ack} !== {1'b1, 1'b1, 3'd1, 8'h02, 8'h02}) begin
      errors++;
      $display("FAIL wrap_g1: got v=%b d=%b sel=%0d gnt=%h ack=%h, expected v=1 d=1 sel=1 gnt=02 ack=02",
               out_valid, out_data, sel, gnt, ack);
    end
    req = '0;
    @(negedge clk);
  endtask

  // Async reset mid-burst, then first grant back to requester 0.
  task automatic test_async_reset();
    apply_reset();
    req = 8'hFF; din = 8'hFF; out_ready = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({out_valid, gnt} !== {1'b1, 8'h02}) begin
      errors++;
      $display("FAIL areset_pre: got v=%b gnt=%h, expected v=1 gnt=02", out_valid, gnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, sel, gnt, ack, busy} !== 22'd0) begin
      errors++;
      $display("FAIL areset_async: got v=%b d=%b sel=%0d gnt=%h ack=%h busy=%b, expected all zero",
               out_valid, out_data, sel, gnt, ack, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, sel, gnt} !== {1'b1, 3'd0, 8'h01}) begin
      errors++;
      $display("FAIL areset_first: got v=%b sel=%0d gnt=%h, expected v=1 sel=0 gnt=01", out_valid, sel, gnt);
    end
    req = '0;
    @(negedge clk);
  endtask

`ifdef MUX8_SCHED_PRIO0_EN
  // Requester 0 pre-empts a requester-5 burst; rotation then resumes at 6.
  task automatic test_prio0();
    apply_reset();
    req = 8'h20; din = 8'h00; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 8'h20) begin
      errors++;
      $display("FAIL prio_g5: got gnt=%h, expected 20", gnt);
    end
    req = 8'h21;
    @(negedge clk);
    checks++;
    if ({sel, gnt} !== {3'd0, 8'h01}) begin
      errors++;
      $display("FAIL prio_g0: got sel=%0d gnt=%h, expected sel=0 gnt=01", sel, gnt);
    end
    req = 8'h60;
    @(negedge clk);
    checks++;
    if ({sel, gnt} !== {3'd6, 8'h40}) begin
      errors++;
      $display("FAIL prio_g6: got sel=%0d gnt=%h, expected sel=6 gnt=40", sel, gnt);
    end
    req = '0;
    @(negedge clk);
  endtask
`else
  // Without priority, requester 0 waits for the requester-5 burst to finish.
  task automatic test_no_prio0();
    apply_reset();
    req = 8'h20; din = 8'h00; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 8'h20) begin
      errors++;
      $display("FAIL noprio_g5: got gnt=%h, expected 20", gnt);
    end
    req = 8'h21;
    for (int n = 1; n < 4; n++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 8'h20) begin
        errors++;
        $display("FAIL noprio_hold%0d: got gnt=%h, expected 20", n, gnt);
      end
    end
    @(negedge clk);
    checks++;
    if ({sel, gnt} !== {3'd0, 8'h01}) begin
      errors++;
      $display("FAIL noprio_g0: got sel=%0d gnt=%h, expected sel=0 gnt=01", sel, gnt);
    end
    req = '0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_stall();
    test_wrap();
    test_async_reset();
`ifdef MUX8_SCHED_PRIO0_EN
    test_prio0();
`else
    test_no_prio0();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
